// File: rtl/char_ram_pkg.sv
// Shared definitions for the character RAM scheduler.
//   ramState_t : scheduler FSM state encoding
//   DEPTH      : default RAM depth (2**8)
//   FILL_BASE  : first address of the line blanked after a scroll
//   NL_CHAR    : newline character, consumed only when NEWLINE_EN is defined
//   depthOf()  : RAM depth for a given address width
package char_ram_pkg;

    typedef enum logic [2:0] {
        ST_CLEAR       = 3'd0,
        ST_IDLE        = 3'd1,
        ST_WRITE       = 3'd2,
        ST_SCROLL_COPY = 3'd3,
        ST_SCROLL_FILL = 3'd4
    } ramState_t;

    localparam int          LINE_LEN_DEF = 32;
    localparam int          DEPTH        = 256;
    localparam int          FILL_BASE    = DEPTH - LINE_LEN_DEF;
    localparam logic [7:0]  NL_CHAR      = 8'h0A;

    function automatic int depthOf(input int addrW);
        return 1 << addrW;
    endfunction

endpackage

// File: rtl/char_ram_scroll_pipe.sv
// Scroll engine read side: walks the source address from LINE_LEN up to the
// last RAM address, competes with the display for the RAM read port, and
// presents each read result's destination one cycle after the read issues.
//   clk, reset : clock, asynchronous active-high reset
//   active     : high while the scheduler is in SCROLL_COPY; low re-arms
//   rdReq      : display read request (display has priority)
//   scrollWin  : scroll owns the read port this cycle (comb)
//   srcAddr    : address scroll reads when it wins
//   wbVld      : ram_dout this cycle is scroll data, write it to wbAddr
//   wbAddr     : destination for ram_dout (source - LINE_LEN)
//   copyDone   : last copy write-back is being presented this cycle
module char_ram_scroll_pipe #(
    parameter int ADDR_W     = 8,
    parameter int LINE_LEN   = 32,
    parameter int STARVE_LIM = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              active,
    input  logic              rdReq,
    output logic              scrollWin,
    output logic [ADDR_W-1:0] srcAddr,
    output logic              wbVld,
    output logic [ADDR_W-1:0] wbAddr,
    output logic              copyDone
);

    localparam int                SW         = $clog2(STARVE_LIM + 1);
    localparam logic [ADDR_W-1:0] LINE_START = ADDR_W'(LINE_LEN);
    localparam logic [ADDR_W-1:0] ADDR_MAX   = '1;
    localparam logic [SW-1:0]     STARVED    = SW'(STARVE_LIM);

    logic [ADDR_W-1:0] srcCnt;
    logic              allIssued;
    logic [SW-1:0]     starveCnt;
    logic              wantRead;
    logic              vld_p1;
    logic              last_p1;
    logic [ADDR_W-1:0] wbAddr_p1;

    // The starvation count only advances while scroll actually wants the port.
    assign wantRead  = active && !allIssued;
    assign scrollWin = wantRead && (!rdReq || (starveCnt == STARVED));
    assign srcAddr   = srcCnt;

    // ---- stage p0 -> p1: read issued, result arrives next cycle ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            srcCnt    <= LINE_START;
            allIssued <= 1'b0;
            starveCnt <= '0;
            vld_p1    <= 1'b0;
            last_p1   <= 1'b0;
        end else if (!active) begin
            srcCnt    <= LINE_START;
            allIssued <= 1'b0;
            starveCnt <= '0;
            vld_p1    <= 1'b0;
            last_p1   <= 1'b0;
        end else begin
            vld_p1  <= scrollWin;
            last_p1 <= scrollWin && (srcCnt == ADDR_MAX);
            if (scrollWin) begin
                srcCnt    <= srcCnt + 1'b1;
                starveCnt <= '0;
                if (srcCnt == ADDR_MAX) begin
                    allIssued <= 1'b1;
                end
            end else if (wantRead) begin
                starveCnt <= starveCnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        wbAddr_p1 <= srcCnt - LINE_START;
    end

    assign wbVld    = vld_p1;
    assign wbAddr   = wbAddr_p1;
    assign copyDone = vld_p1 && last_p1;

endmodule

// File: rtl/char_ram_scheduler.sv
// Character RAM scheduler for the UART terminal: appends received bytes at a
// cursor, clears the screen, scrolls up one line when the cursor wraps, and
// shares the RAM read port between the display fetcher and the scroll engine.
// Optional feature: NEWLINE_EN -- when defined, 8'h0A is not stored; it moves
// the cursor to the start of the next line (scrolling if that wraps).
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   wr_req/wr_data/wr_ack       append handshake (ack = 1-cycle pulse)
//   clr_req                     clear-screen request (level)
//   rd_req/rd_addr/rd_gnt       display read request / address / grant (comb)
//   rd_valid/rd_data            display read data, one cycle after rd_gnt
//   busy                        clear or scroll in progress
//   cursor                      next append address
//   ram_we/ram_waddr/ram_din    registered RAM write port
//   ram_raddr/ram_dout          RAM read port, 1-cycle read latency
module char_ram_scheduler
    import char_ram_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 8,
    parameter int LINE_LEN   = 32,
    parameter int STARVE_LIM = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_req,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    input  logic              clr_req,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_gnt,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic [ADDR_W-1:0] cursor,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_waddr,
    output logic [DATA_W-1:0] ram_din,
    output logic [ADDR_W-1:0] ram_raddr,
    input  logic [DATA_W-1:0] ram_dout
);

    localparam int                MEM_DEPTH  = depthOf(ADDR_W);
    localparam logic [ADDR_W-1:0] ADDR_MAX   = ADDR_W'(MEM_DEPTH - 1);
    localparam logic [ADDR_W-1:0] FILL_START = ADDR_W'(MEM_DEPTH - LINE_LEN);
    localparam logic [ADDR_W-1:0] LINE_MASK  = ADDR_W'(LINE_LEN - 1);

    ramState_t         state, stateNext;
    logic [ADDR_W-1:0] clrCnt, clrCntNext;
    logic [ADDR_W-1:0] cursorNext;
    logic [ADDR_W-1:0] waddrNext;
    logic [DATA_W-1:0] dinNext;
    logic              weNext, ackNext;
    logic              nlHit, nlPend, nlNext;
    logic [ADDR_W-1:0] linePos;
    logic              scrollWin, wbVld, copyDone;
    logic [ADDR_W-1:0] srcAddr, wbAddr;

`ifdef NEWLINE_EN
    assign nlHit = (wr_data == DATA_W'(NL_CHAR));
`else
    assign nlHit = 1'b0;
`endif

    // A newline advances to the last slot of the current line, then +1 as usual.
    assign linePos = nlPend ? (cursor | LINE_MASK) : cursor;

    assign busy      = (state == ST_CLEAR) || (state == ST_SCROLL_COPY) ||
                       (state == ST_SCROLL_FILL);
    assign rd_gnt    = rd_req && !scrollWin;
    assign ram_raddr = scrollWin ? srcAddr : rd_addr;
    assign rd_data   = ram_dout;

    char_ram_scroll_pipe #(
        .ADDR_W    (ADDR_W),
        .LINE_LEN  (LINE_LEN),
        .STARVE_LIM(STARVE_LIM)
    ) scrollPipe (
        .clk      (clk),
        .reset    (reset),
        .active   (state == ST_SCROLL_COPY),
        .rdReq    (rd_req),
        .scrollWin(scrollWin),
        .srcAddr  (srcAddr),
        .wbVld    (wbVld),
        .wbAddr   (wbAddr),
        .copyDone (copyDone)
    );

    always_comb begin
        stateNext  = state;
        clrCntNext = clrCnt;
        cursorNext = cursor;
        weNext     = 1'b0;
        waddrNext  = clrCnt;
        dinNext    = '0;
        ackNext    = 1'b0;
        nlNext     = nlPend;
        case (state)
            ST_CLEAR: begin
                weNext     = 1'b1;
                clrCntNext = clrCnt + 1'b1;
                if (clrCnt == ADDR_MAX) begin
                    stateNext  = ST_IDLE;
                    cursorNext = '0;
                end
            end
            ST_IDLE: begin
                if (clr_req) begin
                    stateNext  = ST_CLEAR;
                    clrCntNext = '0;
                end else if (wr_req) begin
                    stateNext = ST_WRITE;
                    ackNext   = 1'b1;
                    weNext    = !nlHit;
                    waddrNext = cursor;
                    dinNext   = wr_data;
                    nlNext    = nlHit;
                end
            end
            ST_WRITE: begin
                cursorNext = linePos + 1'b1;
                stateNext  = (linePos == ADDR_MAX) ? ST_SCROLL_COPY : ST_IDLE;
            end
            ST_SCROLL_COPY: begin
                if (clr_req) begin
                    stateNext  = ST_CLEAR;
                    clrCntNext = '0;
                end else begin
                    // Read data for the previous winning cycle is on ram_dout now.
                    weNext    = wbVld;
                    waddrNext = wbAddr;
                    dinNext   = ram_dout;
                    if (copyDone) begin
                        stateNext  = ST_SCROLL_FILL;
                        clrCntNext = FILL_START;
                    end
                end
            end
            ST_SCROLL_FILL: begin
                if (clr_req) begin
                    stateNext  = ST_CLEAR;
                    clrCntNext = '0;
                end else begin
                    weNext     = 1'b1;
                    clrCntNext = clrCnt + 1'b1;
                    if (clrCnt == ADDR_MAX) begin
                        stateNext  = ST_IDLE;
                        cursorNext = FILL_START;
                    end
                end
            end
            default: begin
                stateNext  = ST_CLEAR;
                clrCntNext = '0;
            end
        endcase
    end

    // ---- registered write port and control state ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_CLEAR;
            clrCnt   <= '0;
            cursor   <= '0;
            ram_we   <= 1'b0;
            wr_ack   <= 1'b0;
            rd_valid <= 1'b0;
            nlPend   <= 1'b0;
        end else begin
            state    <= stateNext;
            clrCnt   <= clrCntNext;
            cursor   <= cursorNext;
            ram_we   <= weNext;
            wr_ack   <= ackNext;
            rd_valid <= rd_gnt;
            nlPend   <= nlNext;
        end
    end

    always_ff @(posedge clk) begin
        ram_waddr <= waddrNext;
        ram_din   <= dinNext;
    end

endmodule

// File: tb/tb_char_ram_scheduler.sv
// Bench for char_ram_scheduler: behavioural 256x8 RAM, directed stimulus,
// queue-based scoreboard for append acks and busy operations.
module tb_char_ram_scheduler;
    import char_ram_pkg::*;

    logic       clk;
    logic       reset;
    logic       wr_req;
    logic [7:0] wr_data;
    logic       wr_ack;
    logic       clr_req;
    logic       rd_req;
    logic [7:0] rd_addr;
    logic       rd_gnt;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic       busy;
    logic [7:0] cursor;
    logic       ram_we;
    logic [7:0] ram_waddr;
    logic [7:0] ram_din;
    logic [7:0] ram_raddr;
    logic [7:0] ram_dout;

    logic [7:0] mem [0:DEPTH-1];

    typedef struct { logic we; logic [7:0] addr; logic [7:0] din; } ackT;
    typedef struct { int len; int cur; int gntLow; } opT;
    ackT ackQ[$];
    opT  opQ[$];

    int total = 0;
    int bad   = 0;
    int run   = 0;
    int gLow  = 0;

    char_ram_scheduler dut (
        .clk(clk), .reset(reset),
        .wr_req(wr_req), .wr_data(wr_data), .wr_ack(wr_ack),
        .clr_req(clr_req),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
        .rd_valid(rd_valid), .rd_data(rd_data),
        .busy(busy), .cursor(cursor),
        .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_din(ram_din),
        .ram_raddr(ram_raddr), .ram_dout(ram_dout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (ram_we) mem[ram_waddr] <= ram_din;
        ram_dout <= mem[ram_raddr];
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [7:0] charOf(input int a);
        logic [7:0] c;
        c = a[7:0];
`ifdef NEWLINE_EN
        if (c == 8'h0A) c = 8'h0B;
`endif
        return c;
    endfunction

    function automatic logic [7:0] expectedAt(input int mode, input int a);
        case (mode)
            1:       return (a < FILL_BASE) ? charOf(a + 32) : 8'h00;
            2:       return (a == 0) ? 8'h41 : (a == 1) ? 8'h42 : 8'h00;
            3:       return (a == 0) ? 8'h55 : 8'h00;
            4:       return (a < 198) ? charOf(a + 32) : 8'h00;
            5:       return (a == 0) ? 8'h0A : 8'h00;
            default: return 8'h00;
        endcase
    endfunction

    task automatic checkRam(input string name, input int mode);
        int firstBad;
        firstBad = -1;
        for (int a = 0; a < DEPTH; a++) begin
            if (firstBad < 0 && mem[a] !== expectedAt(mode, a)) firstBad = a;
        end
        total++;
        if (firstBad >= 0) begin
            bad++;
            $display("FAIL %s: RAM[%0d]=%0h, expected %0h", name, firstBad,
                     mem[firstBad], expectedAt(mode, firstBad));
        end
    endtask

    task automatic waitIdle(input string name, input int budget);
        int n;
        n = 0;
        while (!busy && n < 8) begin @(negedge clk); n++; end
        n = 0;
        while (busy && n < budget) begin @(negedge clk); n++; end
        if (busy) begin
            total++;
            bad++;
            $display("FAIL %s: busy still 1 after %0d cycles, expected 0", name, budget);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic append(input logic [7:0] d, input logic expWe, input int expAddr);
        int n;
        ackQ.push_back('{we: expWe, addr: expAddr[7:0], din: d});
        @(posedge clk); #2;
        wr_req  = 1'b1;
        wr_data = d;
        n = 0;
        do begin @(negedge clk); n++; end while (!wr_ack && n < 16);
        wr_req = 1'b0;
        if (!wr_ack) begin
            total++;
            bad++;
            $display("FAIL append_ack: no wr_ack for %0h within 16 cycles", d);
        end
    endtask

    task automatic pulseClear();
        @(posedge clk); #2;
        clr_req = 1'b1;
        @(posedge clk); #2;
        clr_req = 1'b0;
    endtask

    // Monitor: pops expectations whenever the DUT acks an append or ends a busy run.
    initial begin
        ackT a;
        opT  o;
        forever begin
            @(negedge clk);
            if (reset) begin
                run  = 0;
                gLow = 0;
            end else begin
                if (wr_ack) begin
                    if (ackQ.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_ack: wr_ack=1 with nothing pending");
                    end else begin
                        a = ackQ.pop_front();
                        check("ack_we", int'(ram_we), int'(a.we));
                        if (a.we) begin
                            check("ack_waddr", int'(ram_waddr), int'(a.addr));
                            check("ack_din", int'(ram_din), int'(a.din));
                        end
                    end
                end
                if (busy) begin
                    run++;
                    if (rd_req && !rd_gnt) gLow++;
                end else if (run != 0) begin
                    if (opQ.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_busy: busy run of %0d cycles not expected", run);
                    end else begin
                        o = opQ.pop_front();
                        check("busy_len", run, o.len);
                        check("busy_cursor", int'(cursor), o.cur);
                        check("gnt_low", gLow, o.gntLow);
                    end
                    run  = 0;
                    gLow = 0;
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset   = 1'b1;
        wr_req  = 1'b0;
        wr_data = 8'h00;
        clr_req = 1'b0;
        rd_req  = 1'b0;
        rd_addr = 8'h00;
        for (int a = 0; a < DEPTH; a++) mem[a] = 8'hFF;

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", int'(busy), 1);
        check("rst_cursor", int'(cursor), 0);
        check("rst_wr_ack", int'(wr_ack), 0);
        check("rst_ram_we", int'(ram_we), 0);
        check("rst_rd_valid", int'(rd_valid), 0);

        // Power-up clear
        opQ.push_back('{len: 256, cur: 0, gntLow: 0});
        @(posedge clk); #2;
        reset = 1'b0;
        waitIdle("reset_clear", 400);
        check("clear_cursor", int'(cursor), 0);
        checkRam("clear_ram", 0);

        // Two appends
        append(8'h41, 1'b1, 0);
        append(8'h42, 1'b1, 1);
        repeat (2) @(negedge clk);
        check("ab_cursor", int'(cursor), 2);
        checkRam("ab_ram", 2);

        // Clear via clr_req, then fill and scroll with no display traffic
        opQ.push_back('{len: 256, cur: 0, gntLow: 0});
        pulseClear();
        waitIdle("clr_req_clear", 400);
        checkRam("clr_req_ram", 0);
        for (int i = 0; i < DEPTH; i++) begin
            if (i == DEPTH - 1) opQ.push_back('{len: 257, cur: FILL_BASE, gntLow: 0});
            append(charOf(i), 1'b1, i);
        end
        waitIdle("scroll_free", 400);
        checkRam("scroll_free_ram", 1);
        check("scroll_free_cursor", int'(cursor), FILL_BASE);

        // Same fill with the display hammering the read port
        opQ.push_back('{len: 256, cur: 0, gntLow: 0});
        pulseClear();
        waitIdle("clear2", 400);
        rd_req  = 1'b1;
        rd_addr = 8'd5;
        for (int i = 0; i < DEPTH; i++) begin
            if (i == DEPTH - 1) opQ.push_back('{len: 1153, cur: FILL_BASE, gntLow: 224});
            append(charOf(i), 1'b1, i);
        end
        waitIdle("scroll_contended", 1400);
        checkRam("scroll_contended_ram", 1);
        check("idle_rd_gnt", int'(rd_gnt), 1);
        check("idle_rd_valid", int'(rd_valid), 1);
        check("idle_rd_data", int'(rd_data), int'(charOf(37)));
        rd_req = 1'b0;

        // clr_req beats a simultaneous wr_req; the held wr_req is served after CLEAR
        opQ.push_back('{len: 256, cur: 0, gntLow: 0});
        ackQ.push_back('{we: 1'b1, addr: 8'd0, din: 8'h55});
        @(posedge clk); #2;
        clr_req = 1'b1;
        wr_req  = 1'b1;
        wr_data = 8'h55;
        @(posedge clk); #2;
        clr_req = 1'b0;
        begin
            int n;
            n = 0;
            do begin @(negedge clk); n++; end while (!wr_ack && n < 400);
            wr_req = 1'b0;
            if (!wr_ack) begin
                total++;
                bad++;
                $display("FAIL held_write_ack: no wr_ack within 400 cycles");
            end
        end
        repeat (3) @(negedge clk);
        check("clr_wr_cursor", int'(cursor), 1);
        checkRam("clr_wr_ram", 3);

        // Reset in the middle of a scroll restarts CLEAR
        for (int i = 1; i < DEPTH; i++) append(charOf(i), 1'b1, i);
        repeat (60) @(negedge clk);
        check("mid_scroll_busy", int'(busy), 1);
        @(posedge clk); #2;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("mid_rst_cursor", int'(cursor), 0);
        check("mid_rst_busy", int'(busy), 1);
        check("mid_rst_we", int'(ram_we), 0);
        opQ.push_back('{len: 256, cur: 0, gntLow: 0});
        @(posedge clk); #2;
        reset = 1'b0;
        waitIdle("mid_rst_clear", 400);
        checkRam("mid_rst_ram", 0);
        check("mid_rst_cursor_after", int'(cursor), 0);

`ifdef NEWLINE_EN
        for (int a = 0; a < 5; a++) append(charOf(a), 1'b1, a);
        append(8'h0A, 1'b0, 0);
        repeat (2) @(negedge clk);
        check("nl_cursor", int'(cursor), 32);
        check("nl_ram5", int'(mem[5]), 0);
        for (int a = 32; a < 230; a++) append(charOf(a), 1'b1, a);
        repeat (2) @(negedge clk);
        check("nl_cursor230", int'(cursor), 230);
        opQ.push_back('{len: 257, cur: FILL_BASE, gntLow: 0});
        append(8'h0A, 1'b0, 0);
        waitIdle("nl_scroll", 400);
        checkRam("nl_scroll_ram", 4);
`else
        append(8'h0A, 1'b1, 0);
        repeat (2) @(negedge clk);
        check("lf_cursor", int'(cursor), 1);
        checkRam("lf_ram", 5);
`endif

        repeat (4) @(negedge clk);
        check("ack_queue_drained", ackQ.size(), 0);
        check("op_queue_drained", opQ.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
